// File: rtl/band_scheduler.sv
// band_scheduler: runs one shared band-filter engine over seven bands for
// every accepted audio sample and publishes the seven 8-bit magnitudes at once.
// Optional build macro BAND_SCHEDULER_PEAK_DECAY_EN enables peak-hold outputs
// with a one-step decay every DECAY_SAMPLES frames.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a sample strobe on ready
// S_ISSUE   | pulse eng_start for the current band, clear timeout counter
// S_WAIT    | wait for eng_done or the timeout terminal count
// S_CAPTURE | convert the captured result into the band's shadow magnitude
// S_PUBLISH | copy all shadows to freq1..freq7 and pulse frame_valid
module band_scheduler #(
   parameter int NUM_BANDS     = 7,
   parameter int MAG_SHIFT     = 9,
   parameter int TIMEOUT       = 64,
   parameter int DECAY_SAMPLES = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ready,
   input  logic [17:0] audio_in,
   output logic        eng_start,
   output logic [2:0]  eng_band,
   output logic [17:0] eng_sample,
   input  logic        eng_done,
   input  logic [17:0] eng_result,
   output logic [7:0]  freq1,
   output logic [7:0]  freq2,
   output logic [7:0]  freq3,
   output logic [7:0]  freq4,
   output logic [7:0]  freq5,
   output logic [7:0]  freq6,
   output logic [7:0]  freq7,
   output logic        frame_valid,
   output logic        busy,
   output logic        overrun,
   output logic        timeout_err
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_PUBLISH} state_t;

   localparam int              TW     = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
   localparam logic [2:0]      B_LAST = 3'(NUM_BANDS - 1);

   state_t                         state_q, state_d;
   logic [2:0]                     band_q, band_d;
   logic [17:0]                    sample_q, sample_d;
   logic [17:0]                    result_q, result_d;
   logic [TW-1:0]                  tcnt_q, tcnt_d;
   logic [NUM_BANDS-1:0][7:0]      shadow_q, shadow_d;
   logic [NUM_BANDS-1:0][7:0]      freq_q, freq_d;
   logic                           frame_valid_q, frame_valid_d;
   logic                           overrun_q, overrun_d;
   logic                           timeout_err_q, timeout_err_d;

`ifdef BAND_SCHEDULER_PEAK_DECAY_EN
   localparam int              DW = $clog2(DECAY_SAMPLES + 1);
   logic [DW-1:0]              dcnt_q, dcnt_d;
   logic                       decay_now;
   logic [7:0]                 base;
`endif

   // |result| with the most negative code folded to the largest positive one,
   // scaled down and saturated to 8 bits
   function automatic logic [7:0] mag8(input logic [17:0] r);
      logic [17:0] a;
      logic [17:0] v;
      if (r == 18'h20000)
         a = 18'h1FFFF;
      else if (r[17])
         a = -r;
      else
         a = r;
      v = a >> MAG_SHIFT;
      return (v > 18'd255) ? 8'hFF : v[7:0];
   endfunction

   // next-state, datapath and handshake decode
   always_comb begin
      state_d       = state_q;
      band_d        = band_q;
      sample_d      = sample_q;
      result_d      = result_q;
      tcnt_d        = tcnt_q;
      shadow_d      = shadow_q;
      freq_d        = freq_q;
      frame_valid_d = 1'b0;
      overrun_d     = overrun_q | (ready && (state_q != S_IDLE));
      timeout_err_d = timeout_err_q;
      eng_start     = 1'b0;
`ifdef BAND_SCHEDULER_PEAK_DECAY_EN
      dcnt_d        = dcnt_q;
      decay_now     = 1'b0;
      base          = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (ready) begin
               sample_d = audio_in;
               band_d   = 3'd0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            eng_start = 1'b1;
            tcnt_d    = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            // a done arriving on the terminal-count cycle still counts as an answer
            if (eng_done) begin
               result_d = eng_result;
               state_d  = S_CAPTURE;
            end else if (tcnt_q == T_LAST) begin
               result_d      = '0;
               timeout_err_d = 1'b1;
               state_d       = S_CAPTURE;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            shadow_d[band_q] = mag8(result_q);
            if (band_q == B_LAST) begin
               state_d = S_PUBLISH;
            end else begin
               band_d  = band_q + 3'd1;
               state_d = S_ISSUE;
            end
         end
         S_PUBLISH: begin
            frame_valid_d = 1'b1;
`ifdef BAND_SCHEDULER_PEAK_DECAY_EN
            decay_now = (dcnt_q == DW'(DECAY_SAMPLES - 1));
            dcnt_d    = decay_now ? '0 : dcnt_q + 1'b1;
            for (int i = 0; i < NUM_BANDS; i++) begin
               base = freq_q[i];
               if (decay_now && (base != 8'd0))
                  base = base - 8'd1;
               freq_d[i] = (shadow_q[i] > base) ? shadow_q[i] : base;
            end
`else
            freq_d = shadow_q;
`endif
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         band_q        <= '0;
         sample_q      <= '0;
         result_q      <= '0;
         tcnt_q        <= '0;
         shadow_q      <= '0;
         freq_q        <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
`ifdef BAND_SCHEDULER_PEAK_DECAY_EN
         dcnt_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         band_q        <= band_d;
         sample_q      <= sample_d;
         result_q      <= result_d;
         tcnt_q        <= tcnt_d;
         shadow_q      <= shadow_d;
         freq_q        <= freq_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
`ifdef BAND_SCHEDULER_PEAK_DECAY_EN
         dcnt_q        <= dcnt_d;
`endif
      end
   end

   assign eng_band    = band_q;
   assign eng_sample  = sample_q;
   assign freq1       = freq_q[0];
   assign freq2       = freq_q[1];
   assign freq3       = freq_q[2];
   assign freq4       = freq_q[3];
   assign freq5       = freq_q[4];
   assign freq6       = freq_q[5];
   assign freq7       = freq_q[6];
   assign frame_valid = frame_valid_q;
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;

endmodule
